// File: rtl/secded_target_pipe_if.sv
// Handshake bundle for secded_target_pipe: codeword input channel, result
// output channel, and the error counter controls/observations.
interface secded_target_pipe_if #(
    parameter int P     = 4,
    parameter int W     = 8,
    parameter int CNT_W = 8
);
    localparam int N = 2 ** P;
    localparam int D = N - P - 1;

    logic             In_valid;
    logic             In_ready;
    logic [N-1:0]     In_word;
    logic             Out_valid;
    logic             Out_ready;
    logic [W-1:0]     Out_target;
    logic [D-1:0]     Out_data;
    logic             Out_err;
    logic             Clr_cnt;
    logic [CNT_W-1:0] Cnt_corr;
    logic [CNT_W-1:0] Cnt_dbl;

    modport master (
        output In_valid, In_word, Out_ready, Clr_cnt,
        input  In_ready, Out_valid, Out_target, Out_data, Out_err, Cnt_corr, Cnt_dbl
    );

    modport slave (
        input  In_valid, In_word, Out_ready, Clr_cnt,
        output In_ready, Out_valid, Out_target, Out_data, Out_err, Cnt_corr, Cnt_dbl
    );
endinterface

// File: rtl/secded_target_pipe.sv
// Two-stage SECDED decoder: stage 1 registers word/syndrome/parity, stage 2
// registers the target code, corrected data and error flag; saturating counters.
module secded_target_pipe #(
    parameter int P     = 4,
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic               Clk,
    input  logic               Reset_n,
    secded_target_pipe_if.slave bus
);
    localparam int N = 2 ** P;
    localparam int D = N - P - 1;
    localparam logic [N-1:0]     ONE_N   = N'(1);
    localparam logic [W-1:0]     T_PAR   = W'(D + 1);
    localparam logic [W-1:0]     T_DBL   = W'(D + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic is_pow2(input logic [P-1:0] s);
        return (s != '0) && ((s & (s - 1'b1)) == '0);
    endfunction

    function automatic logic [P-1:0] calc_syn(input logic [N-1:0] w);
        logic [P-1:0] s;
        s = '0;
        for (int i = 1; i < N; i++) begin
            s = s ^ (w[i] ? P'(i) : '0);
        end
        return s;
    endfunction

    // Data bits sit at the non-power-of-two positions in ascending order.
    function automatic logic [D-1:0] extract(input logic [N-1:0] w);
        logic [D-1:0] d;
        int           k;
        d = '0;
        k = 0;
        for (int i = 1; i < N; i++) begin
            if (!is_pow2(P'(i))) begin
                d[k] = w[i];
                k++;
            end else begin
                k = k;
            end
        end
        return d;
    endfunction

    function automatic logic [W-1:0] syn_to_k(input logic [P-1:0] s);
        logic [W-1:0] k;
        logic [W-1:0] cnt;
        k   = '0;
        cnt = '0;
        for (int i = 1; i < N; i++) begin
            if (!is_pow2(P'(i))) begin
                cnt = cnt + 1'b1;
                k   = (s == P'(i)) ? cnt : k;
            end else begin
                cnt = cnt;
            end
        end
        return k;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [N-1:0]     s1_word_q,  s1_word_d;
    logic [P-1:0]     s1_syn_q,   s1_syn_d;
    logic             s1_pm_q,    s1_pm_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     target_q,   target_d;
    logic [D-1:0]     data_q,     data_d;
    logic             err_q,      err_d;
    logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d;
    logic [CNT_W-1:0] cnt_dbl_q,  cnt_dbl_d;

    logic             adv_s;
    logic             hs_s;
    logic [W-1:0]     tgt_s;
    logic [D-1:0]     dat_s;
    logic             err_s;

    assign adv_s = !out_valid_q || bus.Out_ready;
    assign hs_s  = out_valid_q && bus.Out_ready;

    // Classify the stage-1 word into target code, corrected data and error flag.
    always_comb begin
        tgt_s = '0;
        dat_s = extract(s1_word_q);
        err_s = 1'b0;
        if (!s1_pm_q) begin
            if (s1_syn_q != '0) begin
                tgt_s = T_DBL;
                err_s = 1'b1;
            end else begin
                tgt_s = '0;
            end
        end else if ((s1_syn_q == '0) || is_pow2(s1_syn_q)) begin
            tgt_s = T_PAR;
        end else begin
            tgt_s = syn_to_k(s1_syn_q);
            dat_s = extract(s1_word_q ^ (ONE_N << s1_syn_q));
        end
    end

    // Next-state for both pipeline stages; everything holds while stalled.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_word_d   = s1_word_q;
        s1_syn_d    = s1_syn_q;
        s1_pm_d     = s1_pm_q;
        out_valid_d = out_valid_q;
        target_d    = target_q;
        data_d      = data_q;
        err_d       = err_q;
        if (adv_s) begin
            s1_valid_d  = bus.In_valid;
            out_valid_d = s1_valid_q;
            if (bus.In_valid) begin
                s1_word_d = bus.In_word;
                s1_syn_d  = calc_syn(bus.In_word);
                s1_pm_d   = ^bus.In_word;
            end else begin
                s1_word_d = s1_word_q;
            end
            if (s1_valid_q) begin
                target_d = tgt_s;
                data_d   = dat_s;
                err_d    = err_s;
            end else begin
                target_d = target_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Saturating event counters, counted at the output handshake; clear wins.
    always_comb begin
        cnt_corr_d = cnt_corr_q;
        cnt_dbl_d  = cnt_dbl_q;
        if (bus.Clr_cnt) begin
            cnt_corr_d = '0;
            cnt_dbl_d  = '0;
        end else if (hs_s) begin
            if ((target_q != '0) && (target_q <= T_PAR) && (cnt_corr_q != CNT_MAX)) begin
                cnt_corr_d = cnt_corr_q + 1'b1;
            end else begin
                cnt_corr_d = cnt_corr_q;
            end
            if ((target_q == T_DBL) && (cnt_dbl_q != CNT_MAX)) begin
                cnt_dbl_d = cnt_dbl_q + 1'b1;
            end else begin
                cnt_dbl_d = cnt_dbl_q;
            end
        end else begin
            cnt_corr_d = cnt_corr_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_word_q   <= '0;
            s1_syn_q    <= '0;
            s1_pm_q     <= 1'b0;
            out_valid_q <= 1'b0;
            target_q    <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            cnt_corr_q  <= '0;
            cnt_dbl_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_word_q   <= s1_word_d;
            s1_syn_q    <= s1_syn_d;
            s1_pm_q     <= s1_pm_d;
            out_valid_q <= out_valid_d;
            target_q    <= target_d;
            data_q      <= data_d;
            err_q       <= err_d;
            cnt_corr_q  <= cnt_corr_d;
            cnt_dbl_q   <= cnt_dbl_d;
        end
    end

    assign bus.In_ready   = adv_s;
    assign bus.Out_valid  = out_valid_q;
    assign bus.Out_target = target_q;
    assign bus.Out_data   = data_q;
    assign bus.Out_err    = err_q;
    assign bus.Cnt_corr   = cnt_corr_q;
    assign bus.Cnt_dbl    = cnt_dbl_q;
endmodule

// File: tb/tb_secded_target_pipe.sv
// Directed bench for secded_target_pipe (P=4): a CNT_W=8 instance plus a
// CNT_W=2 instance sharing the same stimulus for the saturation case.
module tb_secded_target_pipe;
    logic Clk;
    logic Reset_n;
    int   checks;
    int   errors;

    secded_target_pipe_if #(.P(4), .W(8), .CNT_W(8)) if0 ();
    secded_target_pipe_if #(.P(4), .W(8), .CNT_W(2)) if1 ();

    secded_target_pipe #(.P(4), .W(8), .CNT_W(8)) u0 (.Clk(Clk), .Reset_n(Reset_n), .bus(if0));
    secded_target_pipe #(.P(4), .W(8), .CNT_W(2)) u1 (.Clk(Clk), .Reset_n(Reset_n), .bus(if1));

    assign if1.In_valid  = if0.In_valid;
    assign if1.In_word   = if0.In_word;
    assign if1.Out_ready = if0.Out_ready;
    assign if1.Clr_cnt   = if0.Clr_cnt;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Push one word with Out_ready high; report valid at latency 1 and 2.
    task automatic run_word(input logic [15:0] w, output logic v1, output logic v2,
                            output logic [7:0] t, output logic [10:0] d, output logic e);
        if0.In_valid = 1'b1;
        if0.In_word  = w;
        tick();
        if0.In_valid = 1'b0;
        v1 = if0.Out_valid;
        tick();
        v2 = if0.Out_valid;
        t  = if0.Out_target;
        d  = if0.Out_data;
        e  = if0.Out_err;
        tick();
    endtask

    task automatic test_reset();
        Reset_n       = 1'b0;
        if0.In_valid  = 1'b0;
        if0.In_word   = 16'h0000;
        if0.Out_ready = 1'b1;
        if0.Clr_cnt   = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
        checks++; if (if0.Out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", if0.Out_valid); end
        checks++; if (if0.Out_target !== 8'd0) begin errors++; $display("FAIL rst_target got %0d exp 0", if0.Out_target); end
        checks++; if (if0.Out_data !== 11'h000) begin errors++; $display("FAIL rst_data got %0h exp 0", if0.Out_data); end
        checks++; if (if0.Out_err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", if0.Out_err); end
        checks++; if (if0.Cnt_corr !== 8'd0 || if0.Cnt_dbl !== 8'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", if0.Cnt_corr, if0.Cnt_dbl); end
        checks++; if (if0.In_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b exp 1", if0.In_ready); end
    endtask

    task automatic test_clean();
        logic v1, v2, e; logic [7:0] t; logic [10:0] d;
        run_word(16'h0000, v1, v2, t, d, e);
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL clean_lat1 got %0b exp 0", v1); end
        checks++; if (v2 !== 1'b1) begin errors++; $display("FAIL clean_lat2 got %0b exp 1", v2); end
        checks++; if (t !== 8'd0 || d !== 11'h000 || e !== 1'b0) begin errors++; $display("FAIL clean_out got t%0d d%0h e%0b exp t0 d0 e0", t, d, e); end
        checks++; if (if0.Cnt_corr !== 8'd0 || if0.Cnt_dbl !== 8'd0) begin errors++; $display("FAIL clean_cnt got %0d/%0d exp 0/0", if0.Cnt_corr, if0.Cnt_dbl); end
    endtask

    task automatic test_classes();
        logic v1, v2, e; logic [7:0] t; logic [10:0] d;
        run_word(16'h0009, v1, v2, t, d, e);
        checks++; if (v2 !== 1'b1 || t !== 8'd13 || d !== 11'h001 || e !== 1'b1) begin errors++; $display("FAIL dbl_s3 got v%0b t%0d d%0h e%0b exp v1 t13 d1 e1", v2, t, d, e); end
        checks++; if (if0.Cnt_dbl !== 8'd1) begin errors++; $display("FAIL dbl_cnt got %0d exp 1", if0.Cnt_dbl); end
        run_word(16'h0008, v1, v2, t, d, e);
        checks++; if (t !== 8'd1 || d !== 11'h000 || e !== 1'b0) begin errors++; $display("FAIL single_s3 got t%0d d%0h e%0b exp t1 d0 e0", t, d, e); end
        checks++; if (if0.Cnt_corr !== 8'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", if0.Cnt_corr); end
    endtask

    task automatic test_flips();
        logic v1, v2, e; logic [7:0] t; logic [10:0] d;
        run_word(16'h0001, v1, v2, t, d, e);
        checks++; if (t !== 8'd12 || d !== 11'h000 || e !== 1'b0) begin errors++; $display("FAIL flip_b0 got t%0d d%0h e%0b exp t12 d0 e0", t, d, e); end
        run_word(16'h0100, v1, v2, t, d, e);
        checks++; if (t !== 8'd12 || d !== 11'h000) begin errors++; $display("FAIL flip_b8 got t%0d d%0h exp t12 d0", t, d); end
        run_word(16'h8000, v1, v2, t, d, e);
        checks++; if (t !== 8'd11 || d !== 11'h000) begin errors++; $display("FAIL flip_b15 got t%0d d%0h exp t11 d0", t, d); end
        run_word(16'h0028, v1, v2, t, d, e);
        checks++; if (t !== 8'd13 || d !== 11'h003 || e !== 1'b1) begin errors++; $display("FAIL flip_b3b5 got t%0d d%0h e%0b exp t13 d3 e1", t, d, e); end
        run_word(16'h0068, v1, v2, t, d, e);
        checks++; if (t !== 8'd12 || d !== 11'h007) begin errors++; $display("FAIL par_s0 got t%0d d%0h exp t12 d7", t, d); end
        run_word(16'h0E00, v1, v2, t, d, e);
        checks++; if (t !== 8'd12 || d !== 11'h070) begin errors++; $display("FAIL par_s8 got t%0d d%0h exp t12 d70", t, d); end
        run_word(16'h1060, v1, v2, t, d, e);
        checks++; if (t !== 8'd11 || d !== 11'h486 || e !== 1'b0) begin errors++; $display("FAIL fix_s15 got t%0d d%0h e%0b exp t11 d486 e0", t, d, e); end
        checks++; if (if0.Cnt_corr !== 8'd7 || if0.Cnt_dbl !== 8'd2) begin errors++; $display("FAIL flip_cnt got %0d/%0d exp 7/2", if0.Cnt_corr, if0.Cnt_dbl); end
    endtask

    task automatic test_back_to_back();
        int         pos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};
        int         idx = 0;
        int         got = 0;
        logic       stalled_prev = 1'b0;
        logic [7:0] prev_t = 8'd0;
        logic       acc;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            if0.Out_ready = !(cyc >= 3 && cyc <= 5);
            if0.In_valid  = (idx < 8);
            if0.In_word   = (idx < 8) ? (16'h0001 << pos[idx]) : 16'h0000;
            #1;
            if (stalled_prev) begin
                checks++; if (if0.Out_valid !== 1'b1 || if0.Out_target !== prev_t) begin errors++; $display("FAIL b2b_hold cyc%0d got v%0b t%0d exp v1 t%0d", cyc, if0.Out_valid, if0.Out_target, prev_t); end
            end
            if (if0.Out_valid && !if0.Out_ready) begin
                checks++; if (if0.In_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready cyc%0d got %0b exp 0", cyc, if0.In_ready); end
            end
            stalled_prev = if0.Out_valid && !if0.Out_ready;
            prev_t       = if0.Out_target;
            acc          = if0.In_valid && if0.In_ready;
            if (if0.Out_valid && if0.Out_ready) begin
                checks++; if (if0.Out_target !== 8'(got + 1) || if0.Out_data !== 11'h000) begin errors++; $display("FAIL b2b_order n%0d got t%0d d%0h exp t%0d d0", got, if0.Out_target, if0.Out_data, got + 1); end
                got++;
            end
            tick();
            if (acc) idx++;
        end
        if0.In_valid  = 1'b0;
        if0.Out_ready = 1'b1;
        checks++; if (got !== 8 || idx !== 8) begin errors++; $display("FAIL b2b_count got %0d/%0d exp 8/8", got, idx); end
        tick();
        checks++; if (if0.Out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b exp 0", if0.Out_valid); end
    endtask

    task automatic test_saturate_clear();
        logic v1, v2, e; logic [7:0] t; logic [10:0] d;
        if0.Clr_cnt = 1'b1;
        tick();
        if0.Clr_cnt = 1'b0;
        checks++; if (if1.Cnt_corr !== 2'd0 || if0.Cnt_corr !== 8'd0) begin errors++; $display("FAIL clr_idle got %0d/%0d exp 0/0", if1.Cnt_corr, if0.Cnt_corr); end
        for (int i = 0; i < 5; i++) run_word(16'h0001 << (i + 3), v1, v2, t, d, e);
        checks++; if (if1.Cnt_corr !== 2'd3) begin errors++; $display("FAIL sat_corr got %0d exp 3", if1.Cnt_corr); end
        checks++; if (if0.Cnt_corr !== 8'd5) begin errors++; $display("FAIL wide_corr got %0d exp 5", if0.Cnt_corr); end
        if0.In_valid = 1'b1;
        if0.In_word  = 16'h0020;
        tick();
        if0.In_valid = 1'b0;
        tick();
        checks++; if (if0.Out_valid !== 1'b1) begin errors++; $display("FAIL clr_hs_valid got %0b exp 1", if0.Out_valid); end
        if0.Clr_cnt = 1'b1;
        tick();
        if0.Clr_cnt = 1'b0;
        checks++; if (if0.Cnt_corr !== 8'd0 || if1.Cnt_corr !== 2'd0) begin errors++; $display("FAIL clr_hs got %0d/%0d exp 0/0", if0.Cnt_corr, if1.Cnt_corr); end
    endtask

    task automatic test_reset_inflight();
        logic v1, v2, e; logic [7:0] t; logic [10:0] d;
        logic seen = 1'b0;
        if0.In_valid = 1'b1;
        if0.In_word  = 16'h0008;
        tick();
        if0.In_word  = 16'h0009;
        tick();
        if0.In_valid = 1'b0;
        Reset_n      = 1'b0;
        tick();
        checks++; if (if0.Out_valid !== 1'b0 || if0.Out_target !== 8'd0) begin errors++; $display("FAIL inflight_rst got v%0b t%0d exp v0 t0", if0.Out_valid, if0.Out_target); end
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | if0.Out_valid;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL inflight_emit got %0b exp 0", seen); end
        run_word(16'h8000, v1, v2, t, d, e);
        checks++; if (v1 !== 1'b0 || v2 !== 1'b1 || t !== 8'd11) begin errors++; $display("FAIL post_rst got v%0b%0b t%0d exp v01 t11", v1, v2, t); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_clean();
        test_classes();
        test_flips();
        test_back_to_back();
        test_saturate_clear();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/secded_target_pipe.md
Name: secded_target_pipe

Overview:
- Parametrised, pipelined successor to the combinational syndrome-to-target lookup used for data-memory error handling.
- Accepts one extended-Hamming (SECDED) codeword per handshake and computes the syndrome and overall parity.
- Outputs a target code in the same encoding as the existing table (0 = clean, 1..D = faulty data bit, D+1 = parity-only error, D+2 = uncorrectable), plus corrected data and saturating error counters.
- Sits between the data-memory read path and the program's correction/store logic.

Parameters:
P, 4, number of Hamming parity bits; codeword width N = 2^P, data width D = 2^P - P - 1 (derived)
W, 8, target output width; must satisfy 2^W >= D+3
CNT_W, 8, width of each error counter

Ports:
Clk  input  1  clock, all state on rising edge
Reset_n  input  1  synchronous, active-low reset
In_valid  input  1  In_word valid
In_ready  output  1  block accepts In_word this cycle
In_word  input  N  codeword: bit0 = overall parity, bit i (1..N-1) = Hamming position i
Out_valid  output  1  result valid
Out_ready  input  1  consumer accepts result
Out_target  output  W  target code (encoding below)
Out_data  output  D  corrected data bits
Out_err  output  1  uncorrectable (double) error flag
Clr_cnt  input  1  synchronous clear of both counters
Cnt_corr  output  CNT_W  corrected-event count (data-bit or parity-only)
Cnt_dbl  output  CNT_W  uncorrectable-event count

Behaviour:
- Reset (Reset_n=0 at a rising edge):
  - Out_valid=0, Out_target=0, Out_data=0, Out_err=0, Cnt_corr=0, Cnt_dbl=0.
  - Both pipeline stages are emptied; in-flight words are discarded, not emitted.
- Codeword layout:
  - Parity bits at power-of-two positions.
  - Data bit k-1 at the k-th non-power-of-two position in ascending order (P=4: data bits 0..10 at positions 3,5,6,7,9,10,11,12,13,14,15).
- Syndrome s (P bits): XOR of indices i in 1..N-1 where In_word[i]=1.
- Overall parity: pm = XOR of In_word[N-1:0]; even parity, so pm=1 indicates mismatch.
- Classification:
  - pm=0, s=0: target 0, no correction.
  - pm=0, s!=0: target D+2, Out_err=1, Out_data = raw extracted data with no flip.
  - pm=1, s=0 or s a power of two: target D+1 (parity bit or bit0 in error), data unchanged.
  - pm=1, otherwise: target k, where s is the k-th non-power position; data bit k-1 is inverted.
- Pipeline:
  - Stage 1 registers raw word, s and pm.
  - Stage 2 registers target, data and err.
  - Latency is 2 cycles from the accepting edge to Out_valid=1 when Out_ready is held high.
  - Sustained throughput is 1 word/cycle.
- Handshake:
  - adv = !Out_valid || Out_ready; In_ready = adv (combinational).
  - Both stages advance only when adv=1. Bubbles propagate as invalid.
  - While Out_valid=1 and Out_ready=0, Out_target, Out_data and Out_err hold stable and In_ready=0.
  - In_word is captured only on In_valid && In_ready.
- Counters:
  - Update only on output handshake (Out_valid && Out_ready).
  - Cnt_corr increments for targets 1..D+1; Cnt_dbl increments for target D+2.
  - Both saturate at all-ones; no wrap.
  - Clr_cnt=1 zeroes both counters and wins over a simultaneous increment.
- No X propagation: all N and all syndrome values produce a defined target.

Test Plan:
- Reset, then In_word=16'h0000 accepted (P=4) -> 2 cycles later Out_valid=1, Out_target=0, Out_data=0, Out_err=0; counters remain 0.
- In_word with only bits 3 and 0 set (s=3, pm=0) -> target 13, Out_err=1, Cnt_dbl=1. In_word with only bit 3 set (s=3, pm=1) -> target 1, Out_data=11'h000, Cnt_corr=1.
- Single flips on bit 0, then bit 8 -> target 12 each; bit 15 flipped on all-zero word -> target 11, Out_data=0; bits 3 and 5 flipped -> target 13, Out_err=1.
- Back-to-back stream of 8 words with Out_ready=0 for cycles 3-5 -> In_ready=0 during the stall, outputs held stable, all 8 results emitted in order with none lost or duplicated.
- CNT_W=2: 5 single-bit-error words -> Cnt_corr stops at 3. Clr_cnt asserted in the same cycle as a handshake -> Cnt_corr=0 next cycle.
- Reset_n pulled low with 2 words in flight -> Out_valid=0 next cycle, neither word emitted; first post-reset word appears with latency 2.
